// File: rtl/anim_frame_sequencer_if.sv
// Handshake bundle between the animation sequencer (master) and the plot datapath/VGA side (slave).
// Optional macro ANIM_PAUSE_EN adds the pause input.
interface anim_frame_sequencer_if #(
  parameter int OBJ_BITS = 2
);
  logic                go;
  logic                done;
`ifdef ANIM_PAUSE_EN
  logic                pause;
`endif
  logic [OBJ_BITS-1:0] obj_sel;
  logic                start;
  logic                en_vga;
  logic                en_datapath;
  logic                erase;
  logic                can_move;
  logic                frame_tick;
  logic [2:0]          state;

`ifdef ANIM_PAUSE_EN
  modport master (
    input  go, done, pause,
    output obj_sel, start, en_vga, en_datapath, erase, can_move, frame_tick, state
  );
  modport slave (
    output go, done, pause,
    input  obj_sel, start, en_vga, en_datapath, erase, can_move, frame_tick, state
  );
`else
  modport master (
    input  go, done,
    output obj_sel, start, en_vga, en_datapath, erase, can_move, frame_tick, state
  );
  modport slave (
    output go, done,
    input  obj_sel, start, en_vga, en_datapath, erase, can_move, frame_tick, state
  );
`endif
endinterface

// File: rtl/anim_frame_sequencer.sv
// Multi-object draw/hold/erase/move sequencer with a free-running frame-rate counter.
// Optional macro ANIM_PAUSE_EN: pause input freezes the HOLD phase.
module anim_frame_sequencer #(
  parameter int NUM_OBJ      = 4,
  parameter int OBJ_BITS     = 2,
  parameter int FRAME_CYCLES = 833333,
  parameter int CNT_W        = 20,
  parameter int HOLD_FRAMES  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  anim_frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    DRAW   = 3'b001,
    HOLD   = 3'b010,
    ERASE  = 3'b011,
    UPDATE = 3'b100
  } state_e;

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CNT_W-1:0]    FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [OBJ_BITS-1:0] OBJ_LAST   = OBJ_BITS'(NUM_OBJ - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

  state_e              state_q, state_d;
  logic [OBJ_BITS-1:0] obj_q, obj_d;
  logic [CNT_W-1:0]    frameCnt_q, frameCnt_d;
  logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
  logic                start_q, start_d;
  logic                goSync_q;
  logic                frameTick;
  logic                doneAcc;
  logic                pauseHold;

`ifdef ANIM_PAUSE_EN
  assign pauseHold = bus.pause;
`else
  assign pauseHold = 1'b0;
`endif

  assign frameTick  = (frameCnt_q == FRAME_LAST);
  assign frameCnt_d = frameTick ? '0 : frameCnt_q + CNT_W'(1);
  // A done arriving alongside its own start pulse cannot belong to this object.
  assign doneAcc    = bus.done && !start_q;

  // go is registered once, which gives the two-cycle go-to-start latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      obj_q      <= '0;
      frameCnt_q <= '0;
      holdCnt_q  <= '0;
      start_q    <= 1'b0;
      goSync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      obj_q      <= obj_d;
      frameCnt_q <= frameCnt_d;
      holdCnt_q  <= holdCnt_d;
      start_q    <= start_d;
      goSync_q   <= bus.go;
    end
  end

  always_comb begin
    state_d   = state_q;
    obj_d     = obj_q;
    holdCnt_d = '0;
    start_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (goSync_q) begin
          state_d = DRAW;
          obj_d   = '0;
          start_d = 1'b1;
        end
      end
      DRAW, ERASE: begin
        if (doneAcc) begin
          if (obj_q == OBJ_LAST) begin
            state_d = (state_q == DRAW) ? HOLD : UPDATE;
            obj_d   = '0;
          end else begin
            obj_d   = obj_q + OBJ_BITS'(1);
            start_d = 1'b1;
          end
        end
      end
      HOLD: begin
        holdCnt_d = holdCnt_q;
        if (frameTick && !pauseHold) begin
          if (holdCnt_q == HOLD_LAST) begin
            state_d   = ERASE;
            obj_d     = '0;
            start_d   = 1'b1;
            holdCnt_d = '0;
          end else begin
            holdCnt_d = holdCnt_q + HOLD_W'(1);
          end
        end
      end
      UPDATE: begin
        obj_d   = '0;
        state_d = goSync_q ? DRAW : IDLE;
        start_d = goSync_q;
      end
      default: begin
        state_d = IDLE;
        obj_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.obj_sel     = obj_q;
    bus.start       = start_q;
    bus.frame_tick  = frameTick;
    bus.state       = state_q;
    bus.en_vga      = 1'b0;
    bus.en_datapath = 1'b0;
    bus.erase       = 1'b0;
    bus.can_move    = 1'b0;
    case (state_q)
      DRAW: begin
        bus.en_vga      = 1'b1;
        bus.en_datapath = 1'b1;
      end
      ERASE: begin
        bus.en_vga      = 1'b1;
        bus.en_datapath = 1'b1;
        bus.erase       = 1'b1;
      end
      UPDATE: bus.can_move = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed self-checking bench for anim_frame_sequencer (NUM_OBJ=3, FRAME_CYCLES=10, HOLD_FRAMES=2).
// Define ANIM_PAUSE_EN to include the pause scenario.
module tb_anim_frame_sequencer;

  localparam int NUM_OBJ      = 3;
  localparam int OBJ_BITS     = 2;
  localparam int FRAME_CYCLES = 10;
  localparam int CNT_W        = 4;
  localparam int HOLD_FRAMES  = 2;

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_DRAW   = 3'b001;
  localparam logic [2:0] S_HOLD   = 3'b010;
  localparam logic [2:0] S_ERASE  = 3'b011;
  localparam logic [2:0] S_UPDATE = 3'b100;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   modelCnt;

  anim_frame_sequencer_if #(.OBJ_BITS(OBJ_BITS)) bus ();

  anim_frame_sequencer #(
    .NUM_OBJ(NUM_OBJ), .OBJ_BITS(OBJ_BITS), .FRAME_CYCLES(FRAME_CYCLES),
    .CNT_W(CNT_W), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Reference frame counter: cycles since reset release, modulo FRAME_CYCLES.
  always @(posedge clock or posedge reset) begin
    if (reset) modelCnt <= 0;
    else       modelCnt <= (modelCnt == FRAME_CYCLES - 1) ? 0 : modelCnt + 1;
  end

  always @(negedge clock) begin
    logic expTick;
    if (!reset) begin
      expTick = (modelCnt == FRAME_CYCLES - 1);
      compared++;
      if (bus.frame_tick !== expTick) begin
        mismatched++;
        $display("[TB] FAIL frame_tick t=%0t got %b expected %b", $time, bus.frame_tick, expTick);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    bus.go   = 1'b0;
    bus.done = 1'b0;
`ifdef ANIM_PAUSE_EN
    bus.pause = 1'b0;
`endif
    reset = 1'b1;
    tick();
    obs = {bus.state, bus.obj_sel, bus.start, bus.en_vga, bus.en_datapath, bus.erase, bus.can_move};
    compared++;
    if (obs !== 10'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got %b expected %b", obs, 10'b0);
    end
    reset = 1'b0;
    repeat (9) tick();
    compared++;
    if (bus.frame_tick !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL first_frame_tick got %b expected 1", bus.frame_tick);
    end
  endtask

  task automatic test_draw();
    logic [8:0] obs;
    int ticks;
    bus.go = 1'b1;
    tick();
    compared++;
    if (bus.state !== S_IDLE || bus.start !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL go_latency_1 state=%b start=%b expected IDLE and 0", bus.state, bus.start);
    end
    tick();
    for (int i = 0; i < NUM_OBJ; i++) begin
      obs = {bus.state, bus.obj_sel, bus.start, bus.en_vga, bus.en_datapath, bus.erase};
      compared++;
      if (obs !== {S_DRAW, 2'(i), 4'b1110}) begin
        mismatched++;
        $display("[TB] FAIL draw_start_obj%0d got %b expected %b", i, obs, {S_DRAW, 2'(i), 4'b1110});
      end
      tick();
      compared++;
      if (bus.start !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL draw_start_width_obj%0d got %b expected 0", i, bus.start);
      end
      tick();
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    compared++;
    if ({bus.state, bus.obj_sel, bus.en_vga, bus.start} !== {S_HOLD, 2'd0, 2'b00}) begin
      mismatched++;
      $display("[TB] FAIL hold_entry state=%b obj=%0d en_vga=%b start=%b expected HOLD,0,0,0",
               bus.state, bus.obj_sel, bus.en_vga, bus.start);
    end
    ticks = 0;
    for (int n = 0; n < 100; n++) begin
      if (modelCnt == FRAME_CYCLES - 1) ticks++;
      tick();
      if (ticks == HOLD_FRAMES) break;
      compared++;
      if (bus.state !== S_HOLD) begin
        mismatched++;
        $display("[TB] FAIL hold_stay got %b expected %b after %0d ticks", bus.state, S_HOLD, ticks);
      end
    end
    compared++;
    if ({bus.state, bus.obj_sel, bus.start, bus.erase} !== {S_ERASE, 2'd0, 2'b11}) begin
      mismatched++;
      $display("[TB] FAIL erase_entry state=%b obj=%0d start=%b erase=%b ticks=%0d expected ERASE,0,1,1 after 2",
               bus.state, bus.obj_sel, bus.start, bus.erase, ticks);
    end
  endtask

  task automatic test_full_frame();
    logic [8:0] obs;
    for (int i = 0; i < NUM_OBJ; i++) begin
      obs = {bus.state, bus.obj_sel, bus.start, bus.en_vga, bus.en_datapath, bus.erase};
      compared++;
      if (obs !== {S_ERASE, 2'(i), 4'b1111}) begin
        mismatched++;
        $display("[TB] FAIL erase_obj%0d got %b expected %b", i, obs, {S_ERASE, 2'(i), 4'b1111});
      end
      tick();
      tick();
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    compared++;
    if ({bus.state, bus.can_move, bus.erase, bus.en_vga, bus.start} !== {S_UPDATE, 4'b1000}) begin
      mismatched++;
      $display("[TB] FAIL update state=%b can_move=%b erase=%b en_vga=%b start=%b expected UPDATE,1,0,0,0",
               bus.state, bus.can_move, bus.erase, bus.en_vga, bus.start);
    end
    tick();
    compared++;
    if ({bus.state, bus.obj_sel, bus.start, bus.can_move, bus.erase} !== {S_DRAW, 2'd0, 3'b100}) begin
      mismatched++;
      $display("[TB] FAIL redraw state=%b obj=%0d start=%b can_move=%b erase=%b expected DRAW,0,1,0,0",
               bus.state, bus.obj_sel, bus.start, bus.can_move, bus.erase);
    end
  endtask

  task automatic test_done_ignored();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    compared++;
    if ({bus.state, bus.obj_sel, bus.start} !== {S_DRAW, 2'd0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL done_in_start_cycle state=%b obj=%0d start=%b expected DRAW,0,0",
               bus.state, bus.obj_sel, bus.start);
    end
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    compared++;
    if ({bus.obj_sel, bus.start} !== {2'd1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL done_advance obj=%0d start=%b expected 1,1", bus.obj_sel, bus.start);
    end
    for (int i = 1; i < NUM_OBJ; i++) begin
      tick();
      tick();
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    compared++;
    if ({bus.state, bus.obj_sel, bus.start} !== {S_HOLD, 2'd0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL done_in_hold state=%b obj=%0d start=%b expected HOLD,0,0",
               bus.state, bus.obj_sel, bus.start);
    end
  endtask

  task automatic test_go_drop();
    int n;
    bus.go = 1'b0;
    for (n = 0; n < 100; n++) begin
      if (bus.state !== S_HOLD) break;
      tick();
    end
    compared++;
    if (bus.state !== S_ERASE) begin
      mismatched++;
      $display("[TB] FAIL go_drop_erase got %b expected %b after %0d cycles", bus.state, S_ERASE, n);
    end
    for (int i = 0; i < NUM_OBJ; i++) begin
      compared++;
      if ({bus.state, bus.obj_sel, bus.start} !== {S_ERASE, 2'(i), 1'b1}) begin
        mismatched++;
        $display("[TB] FAIL go_drop_erase_obj%0d state=%b obj=%0d start=%b", i, bus.state, bus.obj_sel, bus.start);
      end
      tick();
      tick();
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    compared++;
    if ({bus.state, bus.can_move} !== {S_UPDATE, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL go_drop_update state=%b can_move=%b expected UPDATE,1", bus.state, bus.can_move);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      compared++;
      if ({bus.state, bus.start, bus.en_vga} !== {S_IDLE, 2'b00}) begin
        mismatched++;
        $display("[TB] FAIL go_drop_idle%0d state=%b start=%b en_vga=%b expected IDLE,0,0",
                 k, bus.state, bus.start, bus.en_vga);
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    logic [9:0] obs;
    bus.go = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.go   = 1'b0;
    tick();
    compared++;
    if ({bus.state, bus.obj_sel} !== {S_DRAW, 2'd1}) begin
      mismatched++;
      $display("[TB] FAIL pre_reset state=%b obj=%0d expected DRAW,1", bus.state, bus.obj_sel);
    end
    #2 reset = 1'b1;
    #1;
    obs = {bus.state, bus.obj_sel, bus.start, bus.en_vga, bus.en_datapath, bus.erase, bus.can_move};
    compared++;
    if (obs !== 10'b0 || bus.frame_tick !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset got %b tick=%b expected all 0", obs, bus.frame_tick);
    end
    tick();
    reset = 1'b0;
    repeat (8) tick();
    compared++;
    if (bus.frame_tick !== 1'b0 || bus.state !== S_IDLE) begin
      mismatched++;
      $display("[TB] FAIL post_reset_count8 tick=%b state=%b expected 0,IDLE", bus.frame_tick, bus.state);
    end
    tick();
    compared++;
    if (bus.frame_tick !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL post_reset_count9 got %b expected 1", bus.frame_tick);
    end
  endtask

`ifdef ANIM_PAUSE_EN
  task automatic test_pause();
    int ticks;
    bus.pause = 1'b1;
    bus.go    = 1'b1;
    tick();
    tick();
    for (int i = 0; i < NUM_OBJ; i++) begin
      tick();
      tick();
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    ticks = 0;
    for (int n = 0; n < 200 && ticks < 5; n++) begin
      if (modelCnt == FRAME_CYCLES - 1) ticks++;
      tick();
      compared++;
      if (bus.state !== S_HOLD) begin
        mismatched++;
        $display("[TB] FAIL pause_hold got %b expected %b ticks=%0d", bus.state, S_HOLD, ticks);
      end
    end
    bus.pause = 1'b0;
    ticks = 0;
    for (int n = 0; n < 100; n++) begin
      if (modelCnt == FRAME_CYCLES - 1) ticks++;
      tick();
      if (ticks == HOLD_FRAMES) break;
      compared++;
      if (bus.state !== S_HOLD) begin
        mismatched++;
        $display("[TB] FAIL pause_release_hold got %b expected %b", bus.state, S_HOLD);
      end
    end
    compared++;
    if (bus.state !== S_ERASE) begin
      mismatched++;
      $display("[TB] FAIL pause_release_erase got %b expected %b", bus.state, S_ERASE);
    end
    bus.go = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_draw();
    test_full_frame();
    test_done_ignored();
    test_go_drop();
    test_reset_mid_draw();
`ifdef ANIM_PAUSE_EN
    test_pause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout reached at t=%0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
